// File: rtl/demux32_buf.sv
// Registered 1-to-2 demultiplexer with a one-entry holding buffer per channel,
// valid/ready handshakes on both sides and a modulo delivered-word count per channel.
module demux32_buf #(
    parameter int WIDTH   = 32,
    parameter int COUNT_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [WIDTH-1:0]   din,
    input  logic               select,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [WIDTH-1:0]   dout_0,
    output logic               out0_valid,
    input  logic               out0_ready,
    output logic [WIDTH-1:0]   dout_1,
    output logic               out1_valid,
    input  logic               out1_ready,
    output logic [COUNT_W-1:0] count_0,
    output logic [COUNT_W-1:0] count_1
);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t             st0_q, st0_d, st1_q, st1_d;
    logic [WIDTH-1:0]   data0_q, data0_d, data1_q, data1_d;
    logic [COUNT_W-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;

    logic accept, acc0, acc1, drn0, drn1;

    // Readiness depends only on the selected channel, so one stalled consumer
    // never blocks traffic headed to the other.
    assign in_ready = select ? ((st1_q == EMPTY) || out1_ready)
                             : ((st0_q == EMPTY) || out0_ready);
    assign accept   = in_valid && in_ready;
    assign acc0     = accept && !select;
    assign acc1     = accept && select;
    assign drn0     = (st0_q == FULL) && out0_ready;
    assign drn1     = (st1_q == FULL) && out1_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st0_q   <= EMPTY;
            st1_q   <= EMPTY;
            data0_q <= '0;
            data1_q <= '0;
            cnt0_q  <= '0;
            cnt1_q  <= '0;
        end else begin
            st0_q   <= st0_d;
            st1_q   <= st1_d;
            data0_q <= data0_d;
            data1_q <= data1_d;
            cnt0_q  <= cnt0_d;
            cnt1_q  <= cnt1_d;
        end
    end

    always_comb begin
        st0_d = st0_q;
        unique case (st0_q)
            EMPTY:   if (acc0) st0_d = FULL;
            FULL:    if (drn0 && !acc0) st0_d = EMPTY;
            default: st0_d = EMPTY;
        endcase

        st1_d = st1_q;
        unique case (st1_q)
            EMPTY:   if (acc1) st1_d = FULL;
            FULL:    if (drn1 && !acc1) st1_d = EMPTY;
            default: st1_d = EMPTY;
        endcase

        // Buffers keep their last word after draining; counters wrap silently.
        data0_d = acc0 ? din : data0_q;
        data1_d = acc1 ? din : data1_q;
        cnt0_d  = drn0 ? cnt0_q + COUNT_W'(1) : cnt0_q;
        cnt1_d  = drn1 ? cnt1_q + COUNT_W'(1) : cnt1_q;
    end

    always_comb begin
        out0_valid = (st0_q == FULL);
        out1_valid = (st1_q == FULL);
        dout_0     = data0_q;
        dout_1     = data1_q;
        count_0    = cnt0_q;
        count_1    = cnt1_q;
    end

endmodule

// File: tb/tb_demux32_buf.sv
// Directed bench for demux32_buf: linear stimulus with immediate-assertion checks.
module tb_demux32_buf;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] din;
    logic        select;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] dout_0, dout_1;
    logic        out0_valid, out1_valid;
    logic        out0_ready, out1_ready;
    logic [7:0]  count_0, count_1;

    int passed = 0;
    int total  = 0;
    int failed = 0;

    demux32_buf #(.WIDTH(32), .COUNT_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (din),
        .select     (select),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .dout_0     (dout_0),
        .out0_valid (out0_valid),
        .out0_ready (out0_ready),
        .dout_1     (dout_1),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready),
        .count_0    (count_0),
        .count_1    (count_1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; din = '0; select = 1'b0; in_valid = 1'b0;
        out0_ready = 1'b0; out1_ready = 1'b0;
        #3;
        chk("rst_v0", {31'd0, out0_valid}, 32'd0);
        chk("rst_v1", {31'd0, out1_valid}, 32'd0);
        chk("rst_inrdy", {31'd0, in_ready}, 32'd1);
        chk("rst_d0", dout_0, 32'd0);
        chk("rst_c0", {24'd0, count_0}, 32'd0);
        tick();
        tick();
        rst_n = 1'b1;

        // Single word into channel 0 with consumer stalled
        din = 32'hff0ff0ff; select = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("single_v0", {31'd0, out0_valid}, 32'd1);
        chk("single_d0", dout_0, 32'hff0ff0ff);
        chk("single_v1", {31'd0, out1_valid}, 32'd0);
        #1 chk("stall_sel0", {31'd0, in_ready}, 32'd0);
        select = 1'b1;
        #1 chk("free_sel1", {31'd0, in_ready}, 32'd1);
        select = 1'b0; out0_ready = 1'b1;
        tick();
        out0_ready = 1'b0;
        chk("single_c0", {24'd0, count_0}, 32'd1);
        chk("single_v0_off", {31'd0, out0_valid}, 32'd0);

        // Streaming alternation, both consumers always ready
        out0_ready = 1'b1; out1_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            din = 32'(i); select = ~i[0]; in_valid = 1'b1;
            #1 chk("stream_inrdy", {31'd0, in_ready}, 32'd1);
            tick();
            if (i[0]) begin
                chk("stream_d0", dout_0, 32'(i));
                chk("stream_v0", {31'd0, out0_valid}, 32'd1);
            end else begin
                chk("stream_d1", dout_1, 32'(i));
                chk("stream_v1", {31'd0, out1_valid}, 32'd1);
            end
        end
        in_valid = 1'b0;
        tick();
        chk("stream_c0", {24'd0, count_0}, 32'd5);
        chk("stream_c1", {24'd0, count_1}, 32'd4);
        chk("stream_v1_off", {31'd0, out1_valid}, 32'd0);

        // Simultaneous drain and accept on channel 1
        out0_ready = 1'b0; out1_ready = 1'b0;
        din = 32'hAAAAAAAA; select = 1'b1; in_valid = 1'b1;
        tick();
        chk("sim_d1_old", dout_1, 32'hAAAAAAAA);
        out1_ready = 1'b1; din = 32'h55555555;
        #1 chk("sim_inrdy", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0; out1_ready = 1'b0;
        chk("sim_c1", {24'd0, count_1}, 32'd5);
        chk("sim_d1_new", dout_1, 32'h55555555);
        chk("sim_v1", {31'd0, out1_valid}, 32'd1);
        out1_ready = 1'b1;
        tick();
        out1_ready = 1'b0;
        chk("sim_c1_drain", {24'd0, count_1}, 32'd6);

        // Independent backpressure: channel 0 stalled, channel 1 streaming
        din = 32'h12345678; select = 1'b0; in_valid = 1'b1;
        tick();
        out1_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            din = 32'hA0 + 32'(k); select = 1'b1; in_valid = 1'b1;
            #1 chk("bp_inrdy1", {31'd0, in_ready}, 32'd1);
            tick();
            chk("bp_d1", dout_1, 32'hA0 + 32'(k));
        end
        in_valid = 1'b0; select = 1'b0;
        #1 chk("bp_inrdy0", {31'd0, in_ready}, 32'd0);
        tick();
        chk("bp_c1", {24'd0, count_1}, 32'd11);
        chk("bp_d0", dout_0, 32'h12345678);
        chk("bp_v0", {31'd0, out0_valid}, 32'd1);
        chk("bp_c0", {24'd0, count_0}, 32'd5);
        out1_ready = 1'b0;

        // Counter wrap on channel 0 (count starts at 5, held word drains first)
        out0_ready = 1'b1; select = 1'b0; in_valid = 1'b1;
        for (int n = 1; n <= 251; n++) begin
            din = 32'h1000 + 32'(n);
            tick();
            if (n == 250) chk("wrap_255", {24'd0, count_0}, 32'd255);
            if (n == 251) chk("wrap_0", {24'd0, count_0}, 32'd0);
        end
        in_valid = 1'b0;
        tick();
        out0_ready = 1'b0;
        chk("wrap_1", {24'd0, count_0}, 32'd1);
        chk("wrap_v0_off", {31'd0, out0_valid}, 32'd0);

        // Reset mid-operation with both channels full and consumers ready
        din = 32'h11111111; select = 1'b0; in_valid = 1'b1;
        tick();
        din = 32'h22222222; select = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("mid_v0", {31'd0, out0_valid}, 32'd1);
        chk("mid_v1", {31'd0, out1_valid}, 32'd1);
        out0_ready = 1'b1; out1_ready = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("mrst_v0", {31'd0, out0_valid}, 32'd0);
        chk("mrst_v1", {31'd0, out1_valid}, 32'd0);
        chk("mrst_d0", dout_0, 32'd0);
        chk("mrst_d1", dout_1, 32'd0);
        chk("mrst_c0", {24'd0, count_0}, 32'd0);
        chk("mrst_c1", {24'd0, count_1}, 32'd0);
        chk("mrst_inrdy", {31'd0, in_ready}, 32'd1);
        tick();
        chk("mrst_c1_hold", {24'd0, count_1}, 32'd0);
        rst_n = 1'b1; out0_ready = 1'b0; out1_ready = 1'b0;
        din = 32'h33333333; select = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("post_v0", {31'd0, out0_valid}, 32'd1);
        chk("post_d0", dout_0, 32'h33333333);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/demux32_buf.md
# demux32_buf

Registered 1-to-2 demultiplexer for 32-bit datapath words: steers each input word to one of two output channels by `select`, buffering it in a per-channel one-entry holding register with a valid/ready handshake on both sides. It is the distributing counterpart of the 2-to-1 `mux32` selector. It sits between a producer (e.g. write-back/store data) and two independent consumers, and keeps a delivered-word count per channel.

## Interface
Parameters:
- `WIDTH`, 32, data word width
- `COUNT_W`, 8, width of per-channel delivered-word counters

Ports:
- `clk`  in  1  single clock; all state updates on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `din`  in  WIDTH  input data word
- `select`  in  1  destination: 0 -> channel 0, 1 -> channel 1
- `in_valid`  in  1  producer presents `din`/`select`
- `in_ready`  out  1  block can accept this cycle
- `dout_0`  out  WIDTH  channel 0 data
- `out0_valid`  out  1  channel 0 holds a word
- `out0_ready`  in  1  consumer 0 takes word
- `dout_1`  out  WIDTH  channel 1 data
- `out1_valid`  out  1  channel 1 holds a word
- `out1_ready`  in  1  consumer 1 takes word
- `count_0`  out  COUNT_W  words delivered on channel 0
- `count_1`  out  COUNT_W  words delivered on channel 1

## Operation
- Each channel has a 2-state FSM: EMPTY (`outN_valid`=0) and FULL (`outN_valid`=1).
- Accept: `in_valid && in_ready` at a rising edge. `din` is loaded into the buffer chosen by `select`, and that channel goes to or stays FULL.
- `in_ready` is combinational. It equals `!outS_valid || outS_ready`, where S = `select`. The other channel's state never affects it.
- Drain: `outN_valid && outN_ready` at an edge. The word is delivered and `count_N` increments by 1.
  - With no accept to that channel in the same cycle, the channel goes FULL -> EMPTY.
- Simultaneous drain and accept on the same channel: the old word is delivered and counted, the new word is loaded, and the channel stays FULL.
- Accept to one channel and drain of the other in the same cycle: both are performed independently.
- `dout_N` holds stable while FULL and not drained.
- After a drain to EMPTY, `dout_N` retains the last value. It is don't-care to consumers.
- Counters are modulo 2^COUNT_W. They wrap from 2^COUNT_W-1 to 0 with no flag.
- `select` and `din` are sampled only on an accept edge. When `in_valid`=0 they are ignored.
- `outN_ready` while EMPTY has no effect and does not count.

## Timing
- Reset (`rst_n`=0, asynchronous, immediate): `out0_valid`=`out1_valid`=0, `dout_0`=`dout_1`=0, `count_0`=`count_1`=0. During reset `in_ready`=1 (both channels EMPTY).
- Reset mid-operation: buffered words are discarded and not counted. Release is synchronous to the next `clk` edge; the first accept is possible on the first edge after deassertion.
- Latency: a word accepted at edge k appears with `outN_valid`=1 after edge k. It is drainable at edge k+1.
- Throughput: one word per cycle per channel when the consumer holds `outN_ready`=1. There are no bubbles, including alternating `select`.
- Backpressure: a FULL channel with `outN_ready`=0 stalls only inputs with `select`=N.
- A count update becomes visible after the drain edge.
- There are no combinational paths from `din` to `dout_N`.
- The only combinational output path is `select`/`outN_ready` -> `in_ready`.

## Test plan
- Reset then single word: `din`=32'hff0ff0ff, `select`=0, `in_valid` for 1 cycle, `out0_ready`=0. Required: `out0_valid`=1 and `dout_0`=32'hff0ff0ff the next cycle, `out1_valid`=0, `in_ready`=0 while `select`=0 and `in_ready`=1 while `select`=1. Then `out0_ready`=1 for 1 cycle. Required: `count_0`=1 and `out0_valid`=0.
- Streaming alternation: 8 words 32'h00000001..32'h00000008 with `select` toggling 0,1,... and both readies held at 1. Required: `in_ready` held at 1, odd values on `dout_0`, even values on `dout_1`, each one cycle after accept, and `count_0`=`count_1`=4.
- Simultaneous drain/accept: channel 1 FULL with 32'hAAAAAAAA, then `out1_ready`=1 and accept 32'h55555555 with `select`=1 in the same cycle. Required: `count_1` increments, `dout_1`=32'h55555555, `out1_valid` stays 1.
- Independent backpressure: channel 0 FULL with `out0_ready`=0, and words with `select`=1 and `out1_ready`=1 over 5 cycles. Required: all 5 delivered on channel 1, `dout_0` unchanged, `count_0`=0.
- Counter wrap (`COUNT_W`=8): 256 deliveries on channel 0. Required: `count_0` passes 255 and then reads 0.
- Reset mid-operation: both channels FULL, assert `rst_n`=0 between edges. Required: valids, data and counts read 0 immediately, with no drain counted.
